seven_seg_scan: RTL and testbench

- Output-side counterpart to the keypad entry path: takes the packed hex-digit word produced by the keypad shift register and shows it on a multiplexed, common-anode 7-segment display.
- Holds a shadow copy of the word and scans one digit at a time.
- Uses a prescaler and a drive/guard FSM, with a blanking gap between digits to suppress ghosting.
- Sits between the keypad/adder datapath and the board display pins.

---
 rtl/seven_seg_scan.sv | 172 +++++++++++++++++
 tb/tb_seven_seg_scan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed common-anode 7-segment scanner.
// Captures a packed hex word into shadow registers on load and scans one digit at a
// time. Each digit is driven for REFRESH_DIV cycles, followed by an optional all-off
// guard gap of GUARD_CYCLES cycles to suppress ghosting. All outputs are registered.
// Optional feature: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is always shown).
module seven_seg_scan #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS*4-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CntMax = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    // Counter only has to hold CntMax-1.
    localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] GuardLast = (GUARD_CYCLES > 0) ? CntW'(GUARD_CYCLES - 1) : '0;
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);
    localparam bit              HasGuard  = (GUARD_CYCLES > 0);

    localparam logic [0:0] StDrive = 1'b0;
    localparam logic [0:0] StGuard = 1'b1;

    logic [DIGITS*4-1:0] shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [0:0]          state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic [IdxW-1:0]     idx_next;
    logic [3:0]          digit_sel;
    logic                dp_sel;
    logic                lit_sel;
    logic [DIGITS-1:0]   an_sel;
    logic [DIGITS-1:0]   keep;

    // Active-low {g,f,e,d,c,b,a} hex decode.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Shadow capture: display only follows value when load is pulsed.
    always_comb begin
        shadow_val_d = load ? value   : shadow_val_q;
        shadow_dp_d  = load ? dp_mask : shadow_dp_q;
    end

    // Drive/guard FSM with shared prescale counter and digit index.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CntW'(1);
        idx_next = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        if (state_q == StDrive) begin
            if (cnt_q == DriveLast) begin
                cnt_d = '0;
                if (HasGuard) begin
                    state_d = StGuard;
                end else begin
                    idx_d = idx_next;
                end
            end
        end else begin
            if (cnt_q == GuardLast) begin
                cnt_d   = '0;
                idx_d   = idx_next;
                state_d = StDrive;
            end
        end
    end

    // Which digits may light: all, or only those at/below the top nonzero digit.
    always_comb begin
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        logic above;
        above = 1'b0;
        keep  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above   = above | (|shadow_val_q[i*4 +: 4]);
            keep[i] = above | (i == 0);
        end
`else
        keep = '1;
`endif
    end

    // Select the current digit and compute next registered outputs.
    always_comb begin
        digit_sel = '0;
        dp_sel    = 1'b0;
        lit_sel   = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                digit_sel = shadow_val_q[i*4 +: 4];
                dp_sel    = shadow_dp_q[i];
                lit_sel   = keep[i];
                an_sel[i] = 1'b0;
            end
        end
        if (state_q == StDrive && lit_sel) begin
            an_d  = an_sel;
            seg_d = hex7(digit_sel);
            dp_d  = ~dp_sel;
        end else begin
            an_d  = '1;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    // State and output registers; reset blanks the display at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            state_q      <= StDrive;
            idx_q        <= '0;
            cnt_q        <= '0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: two instances (guard = 1 and guard = 0),
// a frame-position reference model pushing expectations, a monitor popping them.
module tb_seven_seg_scan;

    localparam int R = 4;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        load;
    logic [3:0]  an_g, an_n;
    logic [6:0]  seg_g, seg_n;
    logic        dp_g, dp_n;

    int tests = 0;
    int fails = 0;

    logic [11:0] q_g[$];
    logic [11:0] q_n[$];

    seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(R), .GUARD_CYCLES(1)) dut_g (
        .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask), .load(load),
        .an(an_g), .seg(seg_g), .dp(dp_g)
    );

    seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(R), .GUARD_CYCLES(0)) dut_n (
        .clk(clk), .reset(reset), .value(value), .dp_mask(dp_mask), .load(load),
        .an(an_n), .seg(seg_n), .dp(dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[d];
    endfunction

    // Expected {an,seg,dp} after the k-th clock edge since reset release.
    function automatic logic [11:0] ref_out(input int k, input logic [15:0] v,
                                            input logic [3:0] m, input int g);
        int          p;
        int          slot;
        int          off;
        logic [15:0] upper;
        logic [3:0]  d;
        logic [3:0]  a;
        p     = (k - 1) % (4 * (R + g));
        slot  = p / (R + g);
        off   = p % (R + g);
        upper = v >> (4 * slot);
        d     = upper[3:0];
        if (off >= R) return {4'hF, 7'h7F, 1'b1};
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (slot > 0 && upper == 16'h0) return {4'hF, 7'h7F, 1'b1};
`endif
        a = ~(4'b0001 << slot);
        return {a, seg_of(d), ~m[slot]};
    endfunction

    // Reference model: one expectation per clock edge for each instance.
    initial begin : model
        int          k;
        logic [15:0] sv;
        logic [3:0]  sm;
        k  = 0;
        sv = '0;
        sm = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                k  = 0;
                sv = '0;
                sm = '0;
                q_g.push_back({4'hF, 7'h7F, 1'b1});
                q_n.push_back({4'hF, 7'h7F, 1'b1});
            end else begin
                k = k + 1;
                q_g.push_back(ref_out(k, sv, sm, 1));
                q_n.push_back(ref_out(k, sv, sm, 0));
                if (load) begin
                    sv = value;
                    sm = dp_mask;
                end
            end
        end
    end

    // Monitor: compare each instance every cycle, away from the active edge.
    initial begin : monitor
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (q_g.size() > 0) begin
                e = q_g.pop_front();
                tests++;
                if ({an_g, seg_g, dp_g} !== e) begin
                    fails++;
                    $display("FAIL guard1_out t=%0t got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                             $time, an_g, seg_g, dp_g, e[11:8], e[7:1], e[0]);
                end
            end
            if (q_n.size() > 0) begin
                e = q_n.pop_front();
                tests++;
                if ({an_n, seg_n, dp_n} !== e) begin
                    fails++;
                    $display("FAIL guard0_out t=%0t got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                             $time, an_n, seg_n, dp_n, e[11:8], e[7:1], e[0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        @(negedge clk);
        #1;
        value   = v;
        dp_mask = m;
        load    = 1'b1;
        @(negedge clk);
        #1;
        load    = 1'b0;
    endtask

    initial begin : stim
        int budget;
        reset   = 1'b1;
        value   = '0;
        dp_mask = '0;
        load    = 1'b0;
        step(3);
        reset = 1'b0;

        // Power-up: zeros on all digits.
        step(45);

        // Directed word with one decimal point.
        do_load(16'h1A8F, 4'b0100);
        step(45);

        // Leading-zero patterns and a full frame of 1234.
        do_load(16'h0070, 4'b0000);
        step(42);
        do_load(16'h0000, 4'b0001);
        step(42);
        do_load(16'h1234, 4'b1010);
        step(40);

        // Value changes without load must not reach the display.
        value   = 16'hFFFF;
        dp_mask = 4'b1111;
        step(25);
        do_load(16'hFFFF, 4'b0000);
        step(25);

        // Random loads at random points within slots.
        for (int i = 0; i < 12; i++) begin
            do_load(16'($urandom()), 4'($urandom_range(0, 15)));
            step($urandom_range(1, 30));
        end

        // Reset while digit 2 is driven: outputs must go dark without a clock edge.
        budget = 0;
        while (an_g !== 4'b1011 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        tests++;
        if (an_g !== 4'b1011) begin
            fails++;
            $display("FAIL wait_digit2 got an=%b want an=1011 within 200 cycles", an_g);
        end
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({an_g, seg_g, dp_g} !== {4'hF, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL async_reset got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1",
                     an_g, seg_g, dp_g);
        end
        step(2);
        reset = 1'b0;
        step(45);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
